thread_ctx: RTL
===============

Name: thread_ctx

Overview:
Parametrised per-thread architectural-state unit for the N-way fine-grained multithreaded 5-stage pipeline. Holds PC, general register file, special registers rm0/rm1/rm2/rm4 and stall flag for every thread. Owns the round-robin fetch scheduler, exception entry and iret. Supersedes the ad-hoc thread-state logic at top level: IF, ID, WB and the exception path connect to it.

Parameters:
N_THREADS, 8, hardware threads; power of two, at least 2; TID_W = $clog2(N_THREADS)
XLEN, 32, word/PC width
N_REGS, 32, GPRs per thread; RID_W = $clog2(N_REGS)
RESET_PC, 32'h1000, PC of every thread after reset
EXC_VECTOR, 32'h2000, handler PC on exception entry

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
fetch_valid  out  1  a thread is selected for fetch this cycle
fetch_thread  out  TID_W  selected thread
fetch_pc  out  XLEN  PC of selected thread
fetch_ack  in  1  IF consumed fetch_pc (no icache/itlb miss)
stall_set  in  N_THREADS  per-thread stall request (cache miss)
stall_clr  in  N_THREADS  per-thread stall release (fill complete)
redir_en  in  1  WB branch/jump redirect
redir_thread  in  TID_W  redirected thread
redir_pc  in  XLEN  redirect target
exc_en  in  1  exception taken at WB
exc_thread  in  TID_W  faulting thread
exc_pc  in  XLEN  faulting PC
exc_addr  in  XLEN  faulting address
exc_cause  in  XLEN  cause code
iret_en  in  1  iret retired at WB
iret_thread  in  TID_W  iret thread
rf_wen  in  1  GPR write
rf_wthread  in  TID_W  write thread
rf_waddr  in  RID_W  write register
rf_wdata  in  XLEN  write data
rf_rthread  in  TID_W  read thread (ID)
rf_raddr1  in  RID_W  read port 1 register
rf_raddr2  in  RID_W  read port 2 register
rf_rdata1  out  XLEN  read port 1 data
rf_rdata2  out  XLEN  read port 2 data
mode  out  N_THREADS  rm4[0] per thread; 1 = supervisor
stalled  out  N_THREADS  current stall flags

Behaviour:
- Reset, for every thread i: pc=RESET_PC; rm0=rm1=rm2=0; rm4=1; stalled=0; all GPRs=0 except R31=i; rr_ptr=0.
- Reset outputs: fetch_valid=0 while rst is high. mode=all ones and stalled=0 from the first cycle after reset.
- Reset asserted mid-operation overrides every other input in that cycle.
- Scheduler, combinational: eligible = ~stalled. Select the first eligible thread scanning rr_ptr, rr_ptr+1, ... modulo N_THREADS. fetch_valid = |eligible.
- Scheduler, registered: on fetch_valid && fetch_ack, rr_ptr <= fetch_thread+1 (wraps at N_THREADS-1 -> 0) and pc[fetch_thread] <= pc+4, wrapping modulo 2^XLEN.
- Scheduler, no ack: rr_ptr and all PCs hold.
- Same-thread PC priority per cycle: exc > iret > redir > fetch increment. The losing updates are dropped, not deferred.
- Exception (exc_en): rm0<=exc_pc; rm1<=exc_addr; rm2<=exc_cause; rm4[1]<=rm4[0]; rm4[0]<=1; pc<=EXC_VECTOR; stalled<=0.
- iret (iret_en): pc<=rm0; rm4[0]<=rm4[1].
- redir_en: pc[redir_thread]<=redir_pc; the PC is not incremented.
- Events on different threads in the same cycle all take effect.
- Stall per thread: set has priority over clr; otherwise clr clears the flag. A stall_set in the same cycle as fetch_ack on that thread still increments the PC.
- Register file: 1 write, 2 combinational read ports. Every register, including R0, is writable.
- Read bypass: when rf_wen && rf_wthread==rf_rthread && rf_waddr==rf_raddrN, rf_rdataN returns rf_wdata in the same cycle.
- Write timing: the write commits at the clock edge.
- Thread-id inputs are always in range (TID_W bits, N_THREADS a power of two).

Decomposition:
- Package common gains threadid_t, regid_t, word_t, vptr_t sized from the parameters, plus exc_cause_t and RESET_PC/EXC_VECTOR defaults.
- One sub-module, rr_arbiter: inputs req[N] and ptr; outputs grant_valid and grant_id. Purely combinational; rr_ptr lives in thread_ctx.

Test Plan:
- Reset, no stalls, fetch_ack held high 10 cycles -> fetch_thread 0,1..7,0,1; pc[0]=0x1008 after both grants; R31 of thread 5 reads 5.
- stall_set[2:1]=2'b11 at rr_ptr=1 -> next grant thread 3. stall_set[2]&stall_clr[2] in the same cycle -> stalled[2] stays 1. All stalled -> fetch_valid=0, PCs unchanged.
- exc_en thread 4, pc 0x1010, addr 0xDEAD, cause 3, simultaneous with redir thread 4 and fetch_ack thread 4 -> pc[4]=0x2000, rm0=0x1010, rm1=0xDEAD, rm2=3, mode[4]=1.
- Thread 6: rm4 forced to 0 by exception-return setup, then exc then iret -> pc[6]=saved rm0, mode[6] restored to 0.
- rf write thread 2 R7=0x55 while reading thread 2 R7 and thread 3 R7 -> same-cycle data 0x55 and 0 respectively.
- pc=0xFFFFFFFC acknowledged -> wraps to 0x0. rst asserted mid-run -> all PCs 0x1000 and rr_ptr=0 next cycle.

Source files
------------

// File: rtl/thread_ctx_pkg.sv
// Shared types and default sizing for the per-thread architectural-state unit.
// Module parameters default to these values; the typedefs describe the default configuration.
package thread_ctx_pkg;

  localparam int unsigned N_THREADS_DEF = 8;
  localparam int unsigned XLEN_DEF      = 32;
  localparam int unsigned N_REGS_DEF    = 32;
  localparam int unsigned TID_W_DEF     = $clog2(N_THREADS_DEF);
  localparam int unsigned RID_W_DEF     = $clog2(N_REGS_DEF);

  localparam logic [XLEN_DEF-1:0] RESET_PC_DEF   = 32'h0000_1000;
  localparam logic [XLEN_DEF-1:0] EXC_VECTOR_DEF = 32'h0000_2000;

  typedef logic [TID_W_DEF-1:0] threadid_t;
  typedef logic [RID_W_DEF-1:0] regid_t;
  typedef logic [XLEN_DEF-1:0]  word_t;
  typedef logic [XLEN_DEF-1:0]  vptr_t;

  typedef enum logic [XLEN_DEF-1:0] {
    CAUSE_NONE      = 32'd0,
    CAUSE_ITLB_MISS = 32'd1,
    CAUSE_DTLB_MISS = 32'd2,
    CAUSE_ILLEGAL   = 32'd3,
    CAUSE_PRIV      = 32'd4
  } exc_cause_t;

  // rm4 keeps only its two meaningful bits: bit 1 = saved mode, bit 0 = current mode.
  typedef struct packed {
    logic prev_sup;
    logic sup;
  } rm4_t;

endpackage

// File: rtl/thread_ctx_if.sv
// Pipeline-facing signal bundle of thread_ctx: fetch, stall, redirect, exception, iret, RF.
interface thread_ctx_if #(
  parameter int unsigned N_THREADS = 8,
  parameter int unsigned XLEN      = 32,
  parameter int unsigned N_REGS    = 32
);
  localparam int unsigned TID_W = $clog2(N_THREADS);
  localparam int unsigned RID_W = $clog2(N_REGS);

  logic                 fetch_valid;
  logic [TID_W-1:0]     fetch_thread;
  logic [XLEN-1:0]      fetch_pc;
  logic                 fetch_ack;
  logic [N_THREADS-1:0] stall_set;
  logic [N_THREADS-1:0] stall_clr;
  logic                 redir_en;
  logic [TID_W-1:0]     redir_thread;
  logic [XLEN-1:0]      redir_pc;
  logic                 exc_en;
  logic [TID_W-1:0]     exc_thread;
  logic [XLEN-1:0]      exc_pc;
  logic [XLEN-1:0]      exc_addr;
  logic [XLEN-1:0]      exc_cause;
  logic                 iret_en;
  logic [TID_W-1:0]     iret_thread;
  logic                 rf_wen;
  logic [TID_W-1:0]     rf_wthread;
  logic [RID_W-1:0]     rf_waddr;
  logic [XLEN-1:0]      rf_wdata;
  logic [TID_W-1:0]     rf_rthread;
  logic [RID_W-1:0]     rf_raddr1;
  logic [RID_W-1:0]     rf_raddr2;
  logic [XLEN-1:0]      rf_rdata1;
  logic [XLEN-1:0]      rf_rdata2;
  logic [N_THREADS-1:0] mode;
  logic [N_THREADS-1:0] stalled;

  modport slave (
    output fetch_valid, fetch_thread, fetch_pc, rf_rdata1, rf_rdata2, mode, stalled,
    input  fetch_ack, stall_set, stall_clr,
           redir_en, redir_thread, redir_pc,
           exc_en, exc_thread, exc_pc, exc_addr, exc_cause,
           iret_en, iret_thread,
           rf_wen, rf_wthread, rf_waddr, rf_wdata,
           rf_rthread, rf_raddr1, rf_raddr2
  );

  modport master (
    input  fetch_valid, fetch_thread, fetch_pc, rf_rdata1, rf_rdata2, mode, stalled,
    output fetch_ack, stall_set, stall_clr,
           redir_en, redir_thread, redir_pc,
           exc_en, exc_thread, exc_pc, exc_addr, exc_cause,
           iret_en, iret_thread,
           rf_wen, rf_wthread, rf_waddr, rf_wdata,
           rf_rthread, rf_raddr1, rf_raddr2
  );
endinterface

// File: rtl/thread_ctx_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping modulo N.
module rr_arbiter #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 grant_valid,
  output logic [$clog2(N)-1:0] grant_id
);
  localparam int unsigned W = $clog2(N);

  logic [W-1:0] idx;

  // Scan from the farthest offset down so the nearest requester to ptr is written last.
  always_comb begin
    grant_id = ptr;
    idx      = '0;
    for (int unsigned k = N; k > 0; k--) begin
      idx = ptr + W'(k - 1);
      if (req[idx]) grant_id = idx;
    end
    grant_valid = |req;
  end
endmodule

// File: rtl/thread_ctx.sv
// Per-thread architectural state: PCs, GPR files, rm0/rm1/rm2/rm4, stall flags,
// the round-robin fetch scheduler, exception entry and iret.
module thread_ctx
  import thread_ctx_pkg::*;
#(
  parameter int unsigned     N_THREADS  = N_THREADS_DEF,
  parameter int unsigned     XLEN       = XLEN_DEF,
  parameter int unsigned     N_REGS     = N_REGS_DEF,
  parameter logic [XLEN-1:0] RESET_PC   = XLEN'(RESET_PC_DEF),
  parameter logic [XLEN-1:0] EXC_VECTOR = XLEN'(EXC_VECTOR_DEF)
) (
  input logic        clk,
  input logic        rst,
  thread_ctx_if.slave ctx
);
  localparam int unsigned TID_W = $clog2(N_THREADS);

  logic [XLEN-1:0]      pc_q  [N_THREADS];
  logic [XLEN-1:0]      pc_d  [N_THREADS];
  logic [XLEN-1:0]      rm0_q [N_THREADS];
  logic [XLEN-1:0]      rm0_d [N_THREADS];
  logic [XLEN-1:0]      rm1_q [N_THREADS];
  logic [XLEN-1:0]      rm1_d [N_THREADS];
  logic [XLEN-1:0]      rm2_q [N_THREADS];
  logic [XLEN-1:0]      rm2_d [N_THREADS];
  rm4_t                 rm4_q [N_THREADS];
  rm4_t                 rm4_d [N_THREADS];
  logic [N_THREADS-1:0] stalled_q, stalled_d;
  logic [TID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [XLEN-1:0]      rf_q  [N_THREADS][N_REGS];

  logic [N_THREADS-1:0] eligible;
  logic                 grant_valid;
  logic [TID_W-1:0]     grant_id;
  logic                 fetch_fire;
  logic                 rd1_hit, rd2_hit;

  assign eligible = ~stalled_q;

  rr_arbiter #(.N(N_THREADS)) u_arb (
    .req         (eligible),
    .ptr         (rr_ptr_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign fetch_fire = grant_valid & ctx.fetch_ack & ~rst;

  // Later assignments win: fetch increment < redirect < iret < exception on the same thread.
  always_comb begin
    rr_ptr_d  = fetch_fire ? grant_id + TID_W'(1) : rr_ptr_q;
    stalled_d = ctx.stall_set | (stalled_q & ~ctx.stall_clr);
    for (int unsigned i = 0; i < N_THREADS; i++) begin
      pc_d[i]  = pc_q[i];
      rm0_d[i] = rm0_q[i];
      rm1_d[i] = rm1_q[i];
      rm2_d[i] = rm2_q[i];
      rm4_d[i] = rm4_q[i];
      if (fetch_fire && grant_id == TID_W'(i))
        pc_d[i] = pc_q[i] + XLEN'(4);
      if (ctx.redir_en && ctx.redir_thread == TID_W'(i))
        pc_d[i] = ctx.redir_pc;
      if (ctx.iret_en && ctx.iret_thread == TID_W'(i)) begin
        pc_d[i]     = rm0_q[i];
        rm4_d[i].sup = rm4_q[i].prev_sup;
      end
      if (ctx.exc_en && ctx.exc_thread == TID_W'(i)) begin
        rm0_d[i]     = ctx.exc_pc;
        rm1_d[i]     = ctx.exc_addr;
        rm2_d[i]     = ctx.exc_cause;
        rm4_d[i]     = '{prev_sup: rm4_q[i].sup, sup: 1'b1};
        pc_d[i]      = EXC_VECTOR;
        stalled_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q  <= '0;
      stalled_q <= '0;
      for (int unsigned i = 0; i < N_THREADS; i++) begin
        pc_q[i]  <= RESET_PC;
        rm0_q[i] <= '0;
        rm1_q[i] <= '0;
        rm2_q[i] <= '0;
        rm4_q[i] <= '{prev_sup: 1'b0, sup: 1'b1};
      end
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      stalled_q <= stalled_d;
      for (int unsigned i = 0; i < N_THREADS; i++) begin
        pc_q[i]  <= pc_d[i];
        rm0_q[i] <= rm0_d[i];
        rm1_q[i] <= rm1_d[i];
        rm2_q[i] <= rm2_d[i];
        rm4_q[i] <= rm4_d[i];
      end
    end
  end

  // R31 of each thread starts holding its own thread id.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_THREADS; i++)
        for (int unsigned r = 0; r < N_REGS; r++)
          rf_q[i][r] <= (r == N_REGS - 1) ? XLEN'(i) : '0;
    end else if (ctx.rf_wen) begin
      rf_q[ctx.rf_wthread][ctx.rf_waddr] <= ctx.rf_wdata;
    end
  end

  assign rd1_hit = ctx.rf_wen && ctx.rf_wthread == ctx.rf_rthread && ctx.rf_waddr == ctx.rf_raddr1;
  assign rd2_hit = ctx.rf_wen && ctx.rf_wthread == ctx.rf_rthread && ctx.rf_waddr == ctx.rf_raddr2;

  assign ctx.rf_rdata1 = rd1_hit ? ctx.rf_wdata : rf_q[ctx.rf_rthread][ctx.rf_raddr1];
  assign ctx.rf_rdata2 = rd2_hit ? ctx.rf_wdata : rf_q[ctx.rf_rthread][ctx.rf_raddr2];

  assign ctx.fetch_valid  = grant_valid & ~rst;
  assign ctx.fetch_thread = grant_id;
  assign ctx.fetch_pc     = pc_q[grant_id];
  assign ctx.stalled      = stalled_q;

  always_comb begin
    ctx.mode = '0;
    for (int unsigned i = 0; i < N_THREADS; i++) ctx.mode[i] = rm4_q[i].sup;
  end
endmodule
